// File: rtl/uart_pkg.sv
// Shared UART timing types and the divisor derivation used by the baud generator.
package uart_pkg;
  localparam int unsigned DIV_W   = 16;
  localparam int unsigned FRAC_W  = 8;
  localparam int unsigned OVS_DEF = 16;

  typedef struct packed {
    logic [DIV_W-1:0]  i;
    logic [FRAC_W-1:0] f;
  } div_t;

  // Fixed-point clocks per oversample period: (clkr << FRAC_W) / (br * ovs).
  function automatic longint unsigned calc_div(input longint unsigned clkr,
                                               input longint unsigned br,
                                               input longint unsigned ovs);
    return (clkr << FRAC_W) / (br * ovs);
  endfunction
endpackage

// File: rtl/frac_divider.sv
// Fractional period counter: periods of I or I+1 clocks, averaging I+F/2^FRAC_W.
module frac_divider #(
  parameter int unsigned       DIV_W   = 16,
  parameter int unsigned       FRAC_W  = 8,
  parameter logic [DIV_W-1:0]  RST_CNT = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sync,
  input  logic              load,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [FRAC_W-1:0] div_f,
  output logic              tick_ev,
  output logic              os_tick
);
  logic [DIV_W-1:0]  cnt, i_eff;
  logic [FRAC_W-1:0] acc, acc_sum;
  logic              carry;

  assign i_eff            = (div_i == '0) ? DIV_W'(1) : div_i;
  assign {carry, acc_sum} = {1'b0, acc} + {1'b0, div_f};
  assign tick_ev          = enable && !sync && (cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= RST_CNT;
      acc     <= '0;
      os_tick <= 1'b0;
    end else if (!enable) begin
      cnt     <= i_eff - DIV_W'(1);
      acc     <= '0;
      os_tick <= 1'b0;
    end else if (sync) begin
      // The sync cycle itself is the first cycle of the restarted period.
      cnt     <= (i_eff == DIV_W'(1)) ? '0 : i_eff - DIV_W'(2);
      acc     <= '0;
      os_tick <= 1'b0;
    end else if (cnt == '0) begin
      os_tick <= 1'b1;
      if (load) begin
        cnt <= i_eff - DIV_W'(1);
      end else begin
        cnt <= i_eff - DIV_W'(1) + {{(DIV_W-1){1'b0}}, carry};
        acc <= acc_sum;
      end
    end else begin
      cnt     <= cnt - DIV_W'(1);
      os_tick <= 1'b0;
    end
  end
endmodule

// File: rtl/baud_tick_gen.sv
// Programmable UART baud generator: oversample, bit, mid-bit strobes and a square baud clock.
module baud_tick_gen
  import uart_pkg::calc_div;
  import uart_pkg::OVS_DEF;
#(
  parameter longint unsigned CLKR    = 50000000,
  parameter longint unsigned BR      = 115200,
  parameter int unsigned     OVS     = OVS_DEF,
  parameter int unsigned     DIV_W   = uart_pkg::DIV_W,
  parameter int unsigned     FRAC_W  = uart_pkg::FRAC_W,
  parameter longint unsigned DEF_DIV = calc_div(CLKR, BR, OVS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    sync,
  input  logic [DIV_W+FRAC_W-1:0] cfg_div,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  output logic                    os_tick,
  output logic                    baud_tick,
  output logic                    mid_tick,
  output logic                    baud_clock
);
  localparam int unsigned       W     = DIV_W + FRAC_W;
  localparam logic [W-1:0]      DEF   = W'(DEF_DIV);
  localparam logic [DIV_W-1:0]  DEF_I = DEF[W-1:FRAC_W];
  localparam int unsigned       IDX_W = $clog2(OVS);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(OVS - 1);
  localparam logic [IDX_W-1:0]  MID   = IDX_W'(OVS/2 - 1);

  if (BR == 0 || CLKR == 0) begin : g_bad_rate
    $fatal(1, "baud_tick_gen: CLKR and BR must be non-zero");
  end
  if (OVS < 4 || OVS > 64 || (OVS & (OVS - 1)) != 0) begin : g_bad_ovs
    $fatal(1, "baud_tick_gen: OVS must be a power of two in 4..64");
  end
  if (DEF_I == '0) begin : g_bad_div
    $fatal(1, "baud_tick_gen: default divisor integer part is zero");
  end

  logic [W-1:0]     div_q, div_nxt;
  logic [IDX_W-1:0] os_idx;
  logic             accept, tick_ev;

  // Enabled loads wait for a period boundary so no period mixes two divisors;
  // the ready pulse blocks a second accept of the same request.
  assign accept  = cfg_valid && !cfg_ready && (!enable || sync || tick_ev);
  assign div_nxt = accept ? cfg_div : div_q;

  frac_divider #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W),
    .RST_CNT(DEF_I - DIV_W'(1))
  ) u_div (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .sync   (sync),
    .load   (accept),
    .div_i  (div_nxt[W-1:FRAC_W]),
    .div_f  (div_nxt[FRAC_W-1:0]),
    .tick_ev(tick_ev),
    .os_tick(os_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= DEF;
      cfg_ready  <= 1'b0;
      os_idx     <= '0;
      baud_tick  <= 1'b0;
      mid_tick   <= 1'b0;
      baud_clock <= 1'b0;
    end else begin
      cfg_ready <= accept;
      if (accept) div_q <= cfg_div;
      if (tick_ev) begin
        os_idx    <= os_idx + IDX_W'(1);
        baud_tick <= (os_idx == LAST);
        mid_tick  <= (os_idx == MID);
        if (os_idx == LAST) baud_clock <= ~baud_clock;
      end else begin
        baud_tick <= 1'b0;
        mid_tick  <= 1'b0;
        if (!enable || sync) os_idx <= '0;
      end
    end
  end
endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen at the default 50 MHz / 115200 / OVS 16 setup.
module tb_baud_tick_gen;
  logic        clk = 1'b0, reset = 1'b0, enable = 1'b0, sync = 1'b0, cfg_valid = 1'b0;
  logic [23:0] cfg_div = '0;
  logic        cfg_ready, os_tick, baud_tick, mid_tick, baud_clock;
  int          checks = 0, errors = 0;

  localparam int OS = 0, BD = 1, MD = 2, RD = 3;

  always #5 clk = ~clk;

  baud_tick_gen dut (
    .clk(clk), .reset(reset), .enable(enable), .sync(sync),
    .cfg_div(cfg_div), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .os_tick(os_tick), .baud_tick(baud_tick), .mid_tick(mid_tick),
    .baud_clock(baud_clock)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic pick(input int w);
    case (w)
      OS:      return os_tick;
      BD:      return baud_tick;
      MD:      return mid_tick;
      default: return cfg_ready;
    endcase
  endfunction

  // Steps until the selected output is high; n = cycles taken, -1 on timeout.
  task automatic wait_sig(input int w, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (pick(w)) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; cfg_valid = 1'b1; cfg_div = 24'h000300;
    step(); step();
    checks++;
    if ({os_tick, baud_tick, mid_tick, baud_clock, cfg_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000",
               {os_tick, baud_tick, mid_tick, baud_clock, cfg_ready});
    end
    enable = 1'b0; cfg_valid = 1'b0;
    step(); reset = 1'b1;
    step();
  endtask

  task automatic test_default();
    int os_at[$], bd_at[$], md_at[$];
    logic bc_at[$];
    enable = 1'b1;
    for (int i = 1; i <= 900; i++) begin
      step();
      if (os_tick) os_at.push_back(i);
      if (mid_tick) md_at.push_back(i);
      if (baud_tick) begin bd_at.push_back(i); bc_at.push_back(baud_clock); end
    end
    checks++;
    if (os_at.size() != 33) begin errors++; $display("FAIL def_os_count got %0d want 33", os_at.size()); end
    checks++;
    if (os_at[0] != 27) begin errors++; $display("FAIL def_first_os got %0d want 27", os_at[0]); end
    checks++;
    if (os_at[7] - os_at[6] != 27) begin errors++; $display("FAIL def_period7 got %0d want 27", os_at[7] - os_at[6]); end
    checks++;
    if (os_at[8] - os_at[7] != 28) begin errors++; $display("FAIL def_period8 got %0d want 28", os_at[8] - os_at[7]); end
    checks++;
    if (md_at[0] != 216) begin errors++; $display("FAIL def_first_mid got %0d want 216", md_at[0]); end
    checks++;
    if (bd_at[0] != 433) begin errors++; $display("FAIL def_first_baud got %0d want 433", bd_at[0]); end
    checks++;
    if (bd_at[1] - bd_at[0] != 434) begin errors++; $display("FAIL def_baud_period got %0d want 434", bd_at[1] - bd_at[0]); end
    checks++;
    if (bc_at.size() != 2 || bc_at[0] !== 1'b1 || bc_at[1] !== 1'b0) begin
      errors++; $display("FAIL def_baud_clock got n=%0d %b%b want n=2 10", bc_at.size(), bc_at[0], bc_at[1]);
    end
  endtask

  task automatic test_enable();
    int n;
    logic noisy = 1'b0, moved = 1'b0;
    wait_sig(BD, 600, n);
    checks++;
    if (n != 401 || baud_clock !== 1'b1) begin
      errors++; $display("FAIL en_third_baud got n=%0d clk=%b want n=401 clk=1", n, baud_clock);
    end
    repeat (50) step();
    enable = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (os_tick || baud_tick || mid_tick || cfg_ready) noisy = 1'b1;
      if (baud_clock !== 1'b1) moved = 1'b1;
    end
    checks++;
    if (noisy !== 1'b0) begin errors++; $display("FAIL en_quiet got strobes=1 want 0"); end
    checks++;
    if (moved !== 1'b0) begin errors++; $display("FAIL en_clock_held got changed want held at 1"); end
    enable = 1'b1;
    wait_sig(OS, 40, n);
    checks++;
    if (n != 27) begin errors++; $display("FAIL en_first_os got %0d want 27", n); end
  endtask

  task automatic test_cfg_load();
    int n;
    cfg_div = 24'h000A00; cfg_valid = 1'b1;
    wait_sig(RD, 40, n);
    checks++;
    if (n != 27 || os_tick !== 1'b1) begin
      errors++; $display("FAIL cfg_ready_on_os got n=%0d os=%b want n=27 os=1", n, os_tick);
    end
    cfg_valid = 1'b0;
    step();
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_pulse got %b want 0", cfg_ready); end
    wait_sig(OS, 20, n);
    checks++;
    if (n != 9) begin errors++; $display("FAIL cfg_os_period got %0d want 9 (+1)", n); end
    wait_sig(OS, 20, n);
    checks++;
    if (n != 10) begin errors++; $display("FAIL cfg_os_period2 got %0d want 10", n); end
    wait_sig(BD, 200, n);
    wait_sig(BD, 200, n);
    checks++;
    if (n != 160) begin errors++; $display("FAIL cfg_baud_period got %0d want 160", n); end
  endtask

  task automatic test_clamp();
    int n, b0 = -1, b1 = -1, m = -1;
    logic gap = 1'b0;
    cfg_div = 24'h000000; cfg_valid = 1'b1;
    wait_sig(RD, 20, n);
    checks++;
    if (n != 10 || os_tick !== 1'b1) begin
      errors++; $display("FAIL clamp_ready got n=%0d os=%b want n=10 os=1", n, os_tick);
    end
    cfg_valid = 1'b0;
    for (int i = 1; i <= 48; i++) begin
      step();
      if (!os_tick) gap = 1'b1;
      if (baud_tick) begin if (b0 < 0) b0 = i; else if (b1 < 0) b1 = i; end
      if (mid_tick && b0 >= 0 && m < 0) m = i;
    end
    checks++;
    if (gap !== 1'b0) begin errors++; $display("FAIL clamp_os_every_cycle got gap want none"); end
    checks++;
    if (b0 < 0 || b1 - b0 != 16) begin errors++; $display("FAIL clamp_baud_period got %0d want 16", b1 - b0); end
    checks++;
    if (b0 < 0 || m - b0 != 8) begin errors++; $display("FAIL clamp_mid_offset got %0d want 8", m - b0); end
  endtask

  task automatic test_sync();
    int n, fo = -1, fm = -1, fb = -1;
    logic noisy = 1'b0;
    cfg_div = 24'h001B20; cfg_valid = 1'b1;
    wait_sig(RD, 5, n);
    checks++;
    if (n != 1) begin errors++; $display("FAIL sync_restore_ready got %0d want 1", n); end
    cfg_valid = 1'b0;
    wait_sig(BD, 500, n);
    repeat (5) step();
    sync = 1'b1;
    for (int i = 1; i <= 440; i++) begin
      step();
      sync = 1'b0;
      if (i <= 26 && (os_tick || baud_tick || mid_tick)) noisy = 1'b1;
      if (os_tick && fo < 0) fo = i;
      if (mid_tick && fm < 0) fm = i;
      if (baud_tick && fb < 0) fb = i;
    end
    checks++;
    if (noisy !== 1'b0) begin errors++; $display("FAIL sync_quiet got strobes=1 want 0"); end
    checks++;
    if (fo != 27) begin errors++; $display("FAIL sync_first_os got %0d want 27", fo); end
    checks++;
    if (fm != 216) begin errors++; $display("FAIL sync_first_mid got %0d want 216", fm); end
    checks++;
    if (fb != 433) begin errors++; $display("FAIL sync_first_baud got %0d want 433", fb); end
  endtask

  task automatic test_reset_mid();
    int n, fo = -1, fm = -1;
    logic rdy = 1'b0;
    wait_sig(OS, 40, n);
    repeat (3) step();
    cfg_div = 24'h000500; cfg_valid = 1'b1;
    step(); step();
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rst_pending got ready=%b want 0", cfg_ready); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({os_tick, baud_tick, mid_tick, baud_clock, cfg_ready} !== 5'b0) begin
      errors++;
      $display("FAIL rst_async got %b want 00000",
               {os_tick, baud_tick, mid_tick, baud_clock, cfg_ready});
    end
    cfg_valid = 1'b0;
    step(); step();
    reset = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (cfg_ready) rdy = 1'b1;
      if (os_tick && fo < 0) fo = i;
      if (mid_tick && fm < 0) fm = i;
    end
    checks++;
    if (fo != 27) begin errors++; $display("FAIL rst_first_os got %0d want 27", fo); end
    checks++;
    if (fm != 216) begin errors++; $display("FAIL rst_first_mid got %0d want 216", fm); end
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL rst_dropped_cfg got ready=1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_default();
    test_enable();
    test_cfg_load();
    test_clamp();
    test_sync();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
